// File: rtl/cmp3_selftest_seq.sv
// ----------------------------------------------------------------------------
// cmp3_selftest_seq
//
// On-chip self-test for a WIDTH-bit magnitude comparator. When asked to run, it
// walks every {A,B} operand pair into the comparator in ascending order, A in
// the upper half. It holds each pair for SETTLE_CYCLES cycles, then samples
// gt/eq/lt and compares them with an internal golden model. The block counts
// failing vectors and remembers the first one. It then reports done/pass.
//
// Ports
//   clk                 in   system clock, rising edge
//   rst_n               in   asynchronous active-low reset
//   i_start             in   run request, honoured only in IDLE or DONE
//   i_abort             in   synchronous abort back to IDLE, wins over start
//   o_a_out             out  operand A driven to the comparator (registered)
//   o_b_out             out  operand B driven to the comparator (registered)
//   i_gt_in             in   comparator says A > B
//   i_eq_in             in   comparator says A == B
//   i_lt_in             in   comparator says A < B
//   o_busy              out  run in progress (SETTLE or CHECK)
//   o_done              out  run finished, held until start/abort/reset
//   o_pass              out  done with zero failures
//   o_err_count         out  failing vectors in the current or last run
//   o_first_fail_valid  out  at least one failure recorded
//   o_first_fail_vec    out  {A,B} of the first failing vector
// ----------------------------------------------------------------------------
module cmp3_selftest_seq #(
    parameter int WIDTH         = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    output logic [WIDTH-1:0]     o_a_out,
    output logic [WIDTH-1:0]     o_b_out,
    input  logic                 i_gt_in,
    input  logic                 i_eq_in,
    input  logic                 i_lt_in,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_pass,
    output logic [2*WIDTH:0]     o_err_count,
    output logic                 o_first_fail_valid,
    output logic [2*WIDTH-1:0]   o_first_fail_vec
);

    localparam int VW = 2 * WIDTH;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [VW-1:0] LAST_VEC   = '1;
    localparam logic [VW:0]   ERR_MAX    = {1'b1, {VW{1'b0}}};
    localparam logic [CW-1:0] CNT_RELOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [VW-1:0]   r_vec;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [VW:0]     r_err;
    logic            r_ff_valid;
    logic [VW-1:0]   r_ff_vec;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [2:0]       w_golden;
    logic             w_fail;

    // The vector index is the operand pair itself. Because it only moves on
    // SETTLE entry, the comparator inputs stay stable through SETTLE and CHECK.
    assign w_a = r_vec[VW-1:WIDTH];
    assign w_b = r_vec[WIDTH-1:0];

    // Any disagreement in any bit fails the vector. This also catches
    // multi-hot and all-zero comparator outputs.
    assign w_golden = {w_a > w_b, w_a == w_b, w_a < w_b};
    assign w_fail   = ({i_gt_in, i_eq_in, i_lt_in} != w_golden);

    assign o_a_out            = w_a;
    assign o_b_out            = w_b;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_pass             = r_done & ~|r_err;
    assign o_err_count        = r_err;
    assign o_first_fail_valid = r_ff_valid;
    assign o_first_fail_vec   = r_ff_vec;

    // Sequencer/checker FSM. Abort is tested before the state case so that it
    // overrides both start and the normal flow. The error count and first-fail
    // capture are left alone on abort, so the partial results stay visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_vec      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= '0;
            r_ff_valid <= 1'b0;
            r_ff_vec   <= '0;
        end else if (i_abort) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state    <= S_SETTLE;
                        r_vec      <= '0;
                        r_cnt      <= CNT_RELOAD;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= '0;
                        r_ff_valid <= 1'b0;
                        r_ff_vec   <= '0;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_CHECK: begin
                    if (w_fail) begin
                        // Only NVEC vectors exist, so the count can never pass
                        // ERR_MAX. The guard keeps the counter from wrapping.
                        if (r_err != ERR_MAX) begin
                            r_err <= r_err + 1'b1;
                        end
                        if (!r_ff_valid) begin
                            r_ff_valid <= 1'b1;
                            r_ff_vec   <= r_vec;
                        end
                    end
                    if (r_vec == LAST_VEC) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_SETTLE;
                        r_vec   <= r_vec + 1'b1;
                        r_cnt   <= CNT_RELOAD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp3_selftest_seq.sv
// ----------------------------------------------------------------------------
// tb_cmp3_selftest_seq
//
// Directed bench for cmp3_selftest_seq. A behavioural comparator model sits
// beside the DUT and can be switched into several faulty modes. Each mode
// produces a known, hand-computed error signature.
// ----------------------------------------------------------------------------
module tb_cmp3_selftest_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [2:0] aOut;
    logic [2:0] bOut;
    logic       gtIn;
    logic       eqIn;
    logic       ltIn;
    logic       busy;
    logic       done;
    logic       pass;
    logic [6:0] errCount;
    logic       ffValid;
    logic [5:0] ffVec;

    int modelMode;
    int testCount;
    int failCount;
    int doneEdge;

    cmp3_selftest_seq dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_start            (start),
        .i_abort            (abort),
        .o_a_out            (aOut),
        .o_b_out            (bOut),
        .i_gt_in            (gtIn),
        .i_eq_in            (eqIn),
        .i_lt_in            (ltIn),
        .o_busy             (busy),
        .o_done             (done),
        .o_pass             (pass),
        .o_err_count        (errCount),
        .o_first_fail_valid (ffValid),
        .o_first_fail_vec   (ffVec)
    );

    // 10 time-unit clock with rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator model. Mode 0 is ideal. Mode 1 has eq stuck at 0. Mode 2
    // inverts gt only for A=5,B=3. Mode 3 drives 3'b111 for every pair.
    always_comb begin
        gtIn = (aOut > bOut);
        eqIn = (aOut == bOut);
        ltIn = (aOut < bOut);
        case (modelMode)
            1: eqIn = 1'b0;
            2: gtIn = (aOut > bOut) ^ ((aOut == 3'd5) && (bOut == 3'd3));
            3: begin
                gtIn = 1'b1;
                eqIn = 1'b1;
                ltIn = 1'b1;
            end
            default: ;
        endcase
    end

    // Advance one rising edge and settle 1 unit past it, so every sample and
    // every input change happens away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One-cycle start pulse. It is driven just after the current edge (the
    // reference edge 0) and captured at the following edge.
    task automatic applyStimulus();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts edges from the reference edge of the last start pulse until
    // done is seen. applyStimulus has already consumed edge 1.
    task automatic waitDone(output int edges);
        int n;
        n = 1;
        while (!done && n < 1000) begin
            tick();
            n++;
        end
        edges = n;
    endtask

    task automatic waitVec(input string tag, input logic [5:0] target);
        int n;
        n = 0;
        while ({aOut, bOut} != target && n < 1000) begin
            tick();
            n++;
        end
        checkOutput(tag, {26'd0, aOut, bOut}, {26'd0, target});
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testCount = 0;
        failCount = 0;
        modelMode = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;

        // Reset state: every output is low while rst_n is asserted.
        tick();
        tick();
        checkOutput("reset_outputs",
                    {9'd0, aOut, bOut, busy, done, pass, errCount, ffValid, ffVec}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        checkOutput("idle_after_reset", {30'd0, busy, done}, 32'd0);

        // 1: ideal comparator, full sweep, done after 64*3+1 edges.
        modelMode = 0;
        applyStimulus();
        checkOutput("t1_busy_after_start", {31'd0, busy}, 32'd1);
        waitDone(doneEdge);
        checkOutput("t1_done_edge", doneEdge, 32'd193);
        checkOutput("t1_pass", {31'd0, pass}, 32'd1);
        checkOutput("t1_err_count", {25'd0, errCount}, 32'd0);
        checkOutput("t1_ff_valid", {31'd0, ffValid}, 32'd0);
        checkOutput("t1_last_a", {29'd0, aOut}, 32'd7);
        checkOutput("t1_last_b", {29'd0, bOut}, 32'd7);
        checkOutput("t1_busy_in_done", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("t1_done_held", {31'd0, done}, 32'd1);

        // 2: eq stuck at 0. The 8 diagonal pairs fail, the first at {0,0}.
        // Starting from DONE must also clear the previous results.
        modelMode = 1;
        applyStimulus();
        checkOutput("t2_restart_clears", {29'd0, done, ffValid, busy}, 32'd1);
        waitDone(doneEdge);
        checkOutput("t2_done_edge", doneEdge, 32'd193);
        checkOutput("t2_err_count", {25'd0, errCount}, 32'd8);
        checkOutput("t2_first_fail", {26'd0, ffVec}, 32'd0);
        checkOutput("t2_ff_valid", {31'd0, ffValid}, 32'd1);
        checkOutput("t2_pass", {31'd0, pass}, 32'd0);

        // 3: gt inverted only at A=5,B=3.
        modelMode = 2;
        applyStimulus();
        waitDone(doneEdge);
        checkOutput("t3_err_count", {25'd0, errCount}, 32'd1);
        checkOutput("t3_first_fail", {26'd0, ffVec}, 32'b101_011);
        checkOutput("t3_pass", {31'd0, pass}, 32'd0);

        // 4: multi-hot 3'b111 everywhere. Every vector fails.
        modelMode = 3;
        applyStimulus();
        waitDone(doneEdge);
        checkOutput("t4_err_count", {25'd0, errCount}, 32'd64);
        checkOutput("t4_first_fail", {26'd0, ffVec}, 32'd0);
        checkOutput("t4_ff_valid", {31'd0, ffValid}, 32'd1);

        // 5: start while busy is ignored, then abort at vec 10.
        modelMode = 1;
        applyStimulus();
        waitVec("t5_reach_vec5", 6'd5);
        applyStimulus();
        checkOutput("t5_start_ignored_vec", {26'd0, aOut, bOut}, 32'd5);
        checkOutput("t5_start_ignored_err", {25'd0, errCount}, 32'd1);
        checkOutput("t5_still_busy", {31'd0, busy}, 32'd1);
        waitVec("t5_reach_vec10", 6'd10);
        checkOutput("t5_err_before_abort", {25'd0, errCount}, 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("t5_abort_flags", {30'd0, busy, done}, 32'd0);
        checkOutput("t5_abort_operands", {26'd0, aOut, bOut}, 32'd0);
        checkOutput("t5_abort_err_held", {25'd0, errCount}, 32'd2);
        checkOutput("t5_abort_ff_held", {25'd0, ffValid, ffVec}, {25'd0, 1'b1, 6'd0});
        tick();
        tick();
        checkOutput("t5_stays_idle", {31'd0, busy}, 32'd0);
        applyStimulus();
        checkOutput("t5_fresh_start", {22'd0, busy, aOut, bOut, errCount[2:0]}, {22'd0, 1'b1, 9'd0});

        // 6: asynchronous reset mid-run at vec 30 (fails at 0, 9, 18, 27).
        waitVec("t6_reach_vec30", 6'd30);
        checkOutput("t6_err_before_reset", {25'd0, errCount}, 32'd4);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_reset_outputs",
                    {9'd0, aOut, bOut, busy, done, pass, errCount, ffValid, ffVec}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("t6_idle_after_release",
                    {9'd0, aOut, bOut, busy, done, pass, errCount, ffValid, ffVec}, 32'd0);
        applyStimulus();
        waitDone(doneEdge);
        checkOutput("t6_rerun_done_edge", doneEdge, 32'd193);
        checkOutput("t6_rerun_err_count", {25'd0, errCount}, 32'd8);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
